axis_fir_ctrl: RTL and testbench
================================

# axis_fir_ctrl

Coefficient-reload controller for the AXI4-Stream FIR datapath. It accepts a coefficient frame on a configuration stream, stalls the sample stream, and writes the taps into the FIR coefficient memory one per cycle. Optionally it flushes the delay line with zeros, then resumes streaming. It sits beside the FIR wrapper, gating its handshakes and driving its enable, coefficient-write and zero-input controls.

## Interface
- NTAPS, 32, number of FIR taps (power of two not required, ≥2)
- COEF_W, 16, coefficient width
- aclk  in  1  clock
- areset  in  1  synchronous reset, active-high
- s_axis_cfg_tdata  in  32  coefficient beat; [COEF_W-1:0] used, rest ignored
- s_axis_cfg_tvalid  in  1  config beat valid
- s_axis_cfg_tlast  in  1  last beat of coefficient frame
- s_axis_cfg_tready  out  1  config beat accepted
- s_axis_tvalid  in  1  sample-stream valid from upstream
- s_axis_tready  out  1  sample-stream ready to upstream
- m_axis_tready  in  1  downstream ready
- m_axis_tvalid  out  1  FIR output valid to downstream
- fir_en  out  1  FIR datapath clock enable
- fir_x_zero  out  1  force FIR input sample to 0
- coef_we  out  1  coefficient write strobe
- coef_addr  out  clog2(NTAPS)  tap index
- coef_data  out  COEF_W  tap value
- busy  out  1  high whenever state ≠ RUN
- err_len  out  1  sticky: last frame length ≠ NTAPS; cleared only by reset or next correct frame

## Operation
- States: RUN, LOAD, ZFILL, FLUSH.
- RUN:
  - s_axis_tready = m_axis_tready, m_axis_tvalid = s_axis_tvalid, fir_en = s_axis_tvalid & m_axis_tready.
  - s_axis_cfg_tvalid=1 → LOAD next cycle. A sample beat in that same cycle is accepted normally.
- LOAD:
  - s_axis_cfg_tready=1, s_axis_tready=0, m_axis_tvalid=0, fir_en=0.
  - Each accepted beat with tap count cnt<NTAPS writes tap cnt, then cnt++.
  - Beats with cnt≥NTAPS are accepted and dropped; err_len set.
  - On accepted tlast:
    - cnt+1=NTAPS → FLUSH (or RUN if flush compiled out); err_len cleared.
    - cnt+1<NTAPS → ZFILL; err_len set.
    - cnt+1>NTAPS → FLUSH/RUN; err_len set.
- ZFILL: cfg_tready=0; writes 0 to taps cnt..NTAPS-1, one per cycle, then FLUSH/RUN.
- FLUSH: fir_en=1, fir_x_zero=1, m_axis_tvalid=0, s_axis_tready=0 for exactly NTAPS cycles, then RUN.
- Tap counter width is clog2(NTAPS+1); it saturates at NTAPS and resets to 0 on entry to LOAD.

## Timing
- Reset values:
  - State RUN, cnt 0.
  - coef_we, coef_addr, coef_data, fir_x_zero, busy, err_len, s_axis_cfg_tready all 0.
  - Sample handshakes pass through per RUN.
- coef_we/coef_addr/coef_data are registered: the write appears the cycle after the beat is accepted.
- cfg_tready is combinational from state only (no dependency on tvalid).
- Full NTAPS frame at one beat/cycle: last write appears 1 cycle after tlast. Flush then takes NTAPS cycles, so RUN resumes NTAPS+1 cycles after the tlast acceptance.
- tvalid gaps in LOAD simply pause writes; there is no timeout.
- Reset mid-LOAD/ZFILL/FLUSH returns immediately to RUN. Partially written coefficients remain in memory.
- cfg tvalid is ignored in ZFILL/FLUSH; it is serviced on the next RUN cycle.

## Configuration
- AXIS_FIR_CTRL_FLUSH_EN
  - Defined: FLUSH state present as above.
  - Undefined: FLUSH removed. LOAD/ZFILL go directly to RUN, fir_x_zero is tied 0, and the delay line retains pre-reload samples.

## Structure
- axis_fir_pkg holds:
  - state enum (RUN, LOAD, ZFILL, FLUSH)
  - default NTAPS and COEF_W constants
  - clog2 helper
- Single flat module; no sub-module is natural (FSM plus one counter).

## Test plan
- Reset, then stream 8 samples with m_axis_tready=1 → fir_en pulses 8 times, busy=0, coef_we never asserted.
- Frame of NTAPS=32 beats with values 1..32 → 32 writes addr 0..31 data 1..32, err_len=0, then 32 FLUSH cycles with fir_x_zero=1 and m_axis_tvalid=0, then RUN.
- Short frame of 5 beats → writes addr 0..4, then ZFILL writes 0 to addr 5..31, err_len=1.
- Long frame of 35 beats → 32 writes, 3 beats dropped with cfg_tready=1, err_len=1. A following 32-beat frame clears err_len.
- cfg_tvalid and sample beat in same RUN cycle → sample accepted (fir_en=1), LOAD next cycle with s_axis_tready=0.
- areset pulse after 10 LOAD beats → next cycle RUN, busy=0, coef_we=0. A fresh frame then restarts at addr 0.

Source files
------------

// File: rtl/axis_fir_pkg.sv
// -----------------------------------------------------------------------------
// axis_fir_pkg
// Shared definitions for the FIR coefficient-reload controller:
//   - state_e     : controller states (RUN, LOAD, ZFILL, FLUSH)
//   - NTAPS_DEF   : default number of FIR taps
//   - COEF_W_DEF  : default coefficient width
//   - clog2()     : ceiling log2, usable in constant expressions
// -----------------------------------------------------------------------------
package axis_fir_pkg;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_LOAD  = 2'd1,
        ST_ZFILL = 2'd2,
        ST_FLUSH = 2'd3
    } state_e;

    localparam int NTAPS_DEF  = 32;
    localparam int COEF_W_DEF = 16;

    // Returns the number of bits needed to index 'value' distinct items
    // (clog2(1) = 0, clog2(32) = 5, clog2(33) = 6).
    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v      = value - 1;
        while (v > 0) begin
            result = result + 1;
            v      = v >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/axis_fir_ctrl.sv
// -----------------------------------------------------------------------------
// axis_fir_ctrl
// Coefficient-reload controller for the AXI4-Stream FIR datapath. A frame on
// the configuration stream stalls the sample stream, its beats are written
// into the FIR coefficient memory one tap per cycle, short frames are padded
// with zero taps, and (optionally) the delay line is flushed with zeros before
// streaming resumes.
//
// Build option:
//   AXIS_FIR_CTRL_FLUSH_EN  defined   -> FLUSH state (NTAPS zero-input cycles)
//                           undefined -> reload returns straight to RUN,
//                                        fir_x_zero tied low
//
// Parameters:
//   NTAPS   number of FIR taps (>= 2)
//   COEF_W  coefficient width
//
// Ports:
//   aclk, areset          clock, synchronous active-high reset
//   s_axis_cfg_t*         coefficient frame input (tdata[COEF_W-1:0] used)
//   s_axis_tvalid/tready  sample stream from upstream (gated)
//   m_axis_tvalid/tready  FIR output stream to downstream (gated)
//   fir_en                FIR datapath clock enable
//   fir_x_zero            force FIR input sample to zero
//   coef_we/addr/data     registered coefficient write port
//   busy                  high whenever not in RUN
//   err_len               sticky frame-length error
// -----------------------------------------------------------------------------
module axis_fir_ctrl
    import axis_fir_pkg::*;
#(
    parameter int NTAPS  = NTAPS_DEF,
    parameter int COEF_W = COEF_W_DEF
) (
    input  logic                      aclk,
    input  logic                      areset,

    input  logic [31:0]               s_axis_cfg_tdata,
    input  logic                      s_axis_cfg_tvalid,
    input  logic                      s_axis_cfg_tlast,
    output logic                      s_axis_cfg_tready,

    input  logic                      s_axis_tvalid,
    output logic                      s_axis_tready,
    input  logic                      m_axis_tready,
    output logic                      m_axis_tvalid,

    output logic                      fir_en,
    output logic                      fir_x_zero,
    output logic                      coef_we,
    output logic [clog2(NTAPS)-1:0]   coef_addr,
    output logic [COEF_W-1:0]         coef_data,
    output logic                      busy,
    output logic                      err_len
);

    localparam int AW = clog2(NTAPS);
    localparam int CW = clog2(NTAPS + 1);

    localparam logic [CW-1:0] CNT_MAX  = CW'(NTAPS);
    localparam logic [CW-1:0] CNT_LAST = CW'(NTAPS - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

`ifdef AXIS_FIR_CTRL_FLUSH_EN
    localparam state_e ST_AFTER_LOAD = ST_FLUSH;
`else
    localparam state_e ST_AFTER_LOAD = ST_RUN;
`endif

    state_e              state_q,     state_d;
    logic [CW-1:0]       cnt_q,       cnt_d;
    logic                coef_we_q,   coef_we_d;
    logic [AW-1:0]       coef_addr_q, coef_addr_d;
    logic [COEF_W-1:0]   coef_data_q, coef_data_d;
    logic                err_len_q,   err_len_d;
`ifdef AXIS_FIR_CTRL_FLUSH_EN
    logic [CW-1:0]       fcnt_q,      fcnt_d;
`endif

    logic cfg_ready;
    logic cfg_beat;

    // Only the low COEF_W bits of a config beat carry a coefficient.
    logic unused_cfg_bits;
    assign unused_cfg_bits = ^s_axis_cfg_tdata;

    // cfg_tready depends on state alone, never on tvalid.
    assign cfg_ready = (state_q == ST_LOAD);
    assign cfg_beat  = cfg_ready & s_axis_cfg_tvalid;

    // -------------------------------------------------------------------------
    // Next-state and write-port logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        coef_we_d   = 1'b0;
        coef_addr_d = coef_addr_q;
        coef_data_d = coef_data_q;
        err_len_d   = err_len_q;
`ifdef AXIS_FIR_CTRL_FLUSH_EN
        fcnt_d      = fcnt_q;
`endif

        case (state_q)
            ST_RUN: begin
                // Sample beats in this cycle still pass; the stall starts next cycle.
                if (s_axis_cfg_tvalid) begin
                    state_d = ST_LOAD;
                    cnt_d   = '0;
                end
            end

            ST_LOAD: begin
                if (cfg_beat) begin
                    if (cnt_q < CNT_MAX) begin
                        coef_we_d   = 1'b1;
                        coef_addr_d = cnt_q[AW-1:0];
                        coef_data_d = s_axis_cfg_tdata[COEF_W-1:0];
                        cnt_d       = cnt_q + CNT_ONE;
                    end else begin
                        // Excess beats are swallowed; counter stays saturated.
                        err_len_d = 1'b1;
                    end

                    if (s_axis_cfg_tlast) begin
`ifdef AXIS_FIR_CTRL_FLUSH_EN
                        fcnt_d = '0;
`endif
                        if (cnt_q == CNT_LAST) begin
                            state_d   = ST_AFTER_LOAD;
                            err_len_d = 1'b0;
                        end else if (cnt_q < CNT_LAST) begin
                            state_d   = ST_ZFILL;
                            err_len_d = 1'b1;
                        end else begin
                            state_d   = ST_AFTER_LOAD;
                            err_len_d = 1'b1;
                        end
                    end
                end
            end

            ST_ZFILL: begin
                // Pad the remaining taps with zero so stale coefficients never survive.
                coef_we_d   = 1'b1;
                coef_addr_d = cnt_q[AW-1:0];
                coef_data_d = '0;
                cnt_d       = cnt_q + CNT_ONE;
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_AFTER_LOAD;
`ifdef AXIS_FIR_CTRL_FLUSH_EN
                    fcnt_d  = '0;
`endif
                end
            end

            ST_FLUSH: begin
`ifdef AXIS_FIR_CTRL_FLUSH_EN
                // NTAPS zero samples push every pre-reload sample out of the delay line.
                fcnt_d = fcnt_q + CNT_ONE;
                if (fcnt_q == CNT_LAST) begin
                    state_d = ST_RUN;
                end
`else
                state_d = ST_RUN;
`endif
            end

            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q     <= ST_RUN;
            cnt_q       <= '0;
            coef_we_q   <= 1'b0;
            coef_addr_q <= '0;
            coef_data_q <= '0;
            err_len_q   <= 1'b0;
`ifdef AXIS_FIR_CTRL_FLUSH_EN
            fcnt_q      <= '0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            coef_we_q   <= coef_we_d;
            coef_addr_q <= coef_addr_d;
            coef_data_q <= coef_data_d;
            err_len_q   <= err_len_d;
`ifdef AXIS_FIR_CTRL_FLUSH_EN
            fcnt_q      <= fcnt_d;
`endif
        end
    end

    // -------------------------------------------------------------------------
    // Stream gating and datapath controls
    // -------------------------------------------------------------------------
    always_comb begin
        s_axis_tready = 1'b0;
        m_axis_tvalid = 1'b0;
        fir_en        = 1'b0;
        case (state_q)
            ST_RUN: begin
                s_axis_tready = m_axis_tready;
                m_axis_tvalid = s_axis_tvalid;
                fir_en        = s_axis_tvalid & m_axis_tready;
            end
            ST_FLUSH: begin
                fir_en = 1'b1;
            end
            default: begin
                fir_en = 1'b0;
            end
        endcase
    end

`ifdef AXIS_FIR_CTRL_FLUSH_EN
    assign fir_x_zero = (state_q == ST_FLUSH);
`else
    assign fir_x_zero = 1'b0;
`endif

    assign s_axis_cfg_tready = cfg_ready;
    assign busy              = (state_q != ST_RUN);
    assign err_len           = err_len_q;
    assign coef_we           = coef_we_q;
    assign coef_addr         = coef_addr_q;
    assign coef_data         = coef_data_q;

endmodule

// File: tb/tb_axis_fir_ctrl.sv
module tb_axis_fir_ctrl;

    localparam int NTAPS  = 32;
    localparam int COEF_W = 16;
    localparam int AW     = 5;
`ifdef AXIS_FIR_CTRL_FLUSH_EN
    localparam int FLUSH_CYC = NTAPS;
`else
    localparam int FLUSH_CYC = 0;
`endif

    logic              aclk = 1'b0;
    logic              areset;
    logic [31:0]       s_axis_cfg_tdata;
    logic              s_axis_cfg_tvalid;
    logic              s_axis_cfg_tlast;
    logic              s_axis_cfg_tready;
    logic              s_axis_tvalid;
    logic              s_axis_tready;
    logic              m_axis_tready;
    logic              m_axis_tvalid;
    logic              fir_en;
    logic              fir_x_zero;
    logic              coef_we;
    logic [AW-1:0]     coef_addr;
    logic [COEF_W-1:0] coef_data;
    logic              busy;
    logic              err_len;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 aclk = ~aclk;

    axis_fir_ctrl #(.NTAPS(NTAPS), .COEF_W(COEF_W)) dut (
        .aclk              (aclk),
        .areset            (areset),
        .s_axis_cfg_tdata  (s_axis_cfg_tdata),
        .s_axis_cfg_tvalid (s_axis_cfg_tvalid),
        .s_axis_cfg_tlast  (s_axis_cfg_tlast),
        .s_axis_cfg_tready (s_axis_cfg_tready),
        .s_axis_tvalid     (s_axis_tvalid),
        .s_axis_tready     (s_axis_tready),
        .m_axis_tready     (m_axis_tready),
        .m_axis_tvalid     (m_axis_tvalid),
        .fir_en            (fir_en),
        .fir_x_zero        (fir_x_zero),
        .coef_we           (coef_we),
        .coef_addr         (coef_addr),
        .coef_data         (coef_data),
        .busy              (busy),
        .err_len           (err_len)
    );

    // Coefficient write log, captured on the falling edge.
    logic [AW-1:0]     wr_addr_log [0:511];
    logic [COEF_W-1:0] wr_data_log [0:511];
    int                wr_cnt = 0;

    always @(negedge aclk) begin
        if (coef_we && wr_cnt < 512) begin
            wr_addr_log[wr_cnt] <= coef_addr;
            wr_data_log[wr_cnt] <= coef_data;
            wr_cnt              <= wr_cnt + 1;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge aclk);
        #1;
    endtask

    // Sends an n-beat frame starting from RUN; beat i carries base+i.
    task automatic send_frame(input int n, input int base);
        int i;
        int cycles;
        i      = 0;
        cycles = 0;
        while (i < n && cycles < n + 20) begin
            s_axis_cfg_tvalid = 1'b1;
            s_axis_cfg_tdata  = 32'(base + i);
            s_axis_cfg_tlast  = (i == n - 1);
            #1;
            if (s_axis_cfg_tready) i++;
            cycles++;
            next_cycle();
        end
        s_axis_cfg_tvalid = 1'b0;
        s_axis_cfg_tlast  = 1'b0;
        if (i < n) check_eq("frame_timeout", i, n);
        check_eq("frame_cycles", cycles, n + 1);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 200) begin
            next_cycle();
            n++;
        end
        if (busy) check_eq("idle_timeout", busy, 0);
    endtask

    // Called right after a full or long frame; watches the post-load window.
    task automatic observe_flush();
        int zc;
        int bad;
        int first;
        zc    = 0;
        bad   = 0;
        first = -1;
        for (int k = 1; k <= NTAPS + 4; k++) begin
            s_axis_tvalid = 1'b1;
            m_axis_tready = 1'b1;
            #1;
            if (fir_x_zero && fir_en) zc++;
            if (busy && (m_axis_tvalid || s_axis_tready)) bad++;
            if (first < 0 && !busy) first = k;
            next_cycle();
        end
        s_axis_tvalid = 1'b0;
        check_eq("flush_cycles", zc, FLUSH_CYC);
        check_eq("flush_gated", bad, 0);
        check_eq("resume_cycle", first, FLUSH_CYC + 1);
    endtask

    task automatic check_writes(input int start, input int n, input int base, input int nonzero);
        check_eq("wr_count", wr_cnt - start, n);
        for (int i = 0; i < n; i++) begin
            check_eq("wr_addr", 32'(wr_addr_log[start + i]), i);
            check_eq("wr_data", 32'(wr_data_log[start + i]), (i < nonzero) ? (base + i) : 0);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int start;
        int en_cnt;
        areset            = 1'b1;
        s_axis_cfg_tdata  = '0;
        s_axis_cfg_tvalid = 1'b0;
        s_axis_cfg_tlast  = 1'b0;
        s_axis_tvalid     = 1'b1;
        m_axis_tready     = 1'b1;
        repeat (3) next_cycle();

        // Reset state, samples pass through
        #1;
        check_eq("rst_busy", busy, 0);
        check_eq("rst_coef_we", coef_we, 0);
        check_eq("rst_coef_addr", coef_addr, 0);
        check_eq("rst_coef_data", coef_data, 0);
        check_eq("rst_x_zero", fir_x_zero, 0);
        check_eq("rst_err_len", err_len, 0);
        check_eq("rst_cfg_tready", s_axis_cfg_tready, 0);
        check_eq("rst_s_tready", s_axis_tready, 1);
        check_eq("rst_m_tvalid", m_axis_tvalid, 1);
        areset        = 1'b0;
        s_axis_tvalid = 1'b0;
        next_cycle();

        // Eight samples in RUN
        start  = wr_cnt;
        en_cnt = 0;
        for (int k = 0; k < 8; k++) begin
            s_axis_tvalid = 1'b1;
            m_axis_tready = 1'b1;
            #1;
            if (fir_en) en_cnt++;
            check_eq("run_busy", busy, 0);
            next_cycle();
        end
        check_eq("run_fir_en_count", en_cnt, 8);
        s_axis_tvalid = 1'b1;
        m_axis_tready = 1'b0;
        #1;
        check_eq("run_backpressure_en", fir_en, 0);
        check_eq("run_backpressure_rdy", s_axis_tready, 0);
        s_axis_tvalid = 1'b0;
        m_axis_tready = 1'b1;
        next_cycle();
        check_eq("run_no_writes", wr_cnt - start, 0);

        // Full 32-beat frame, values 1..32
        start = wr_cnt;
        send_frame(NTAPS, 1);
        check_eq("full_err_len", err_len, 0);
        check_eq("full_last_we", coef_we, 1);
        check_eq("full_last_addr", coef_addr, NTAPS - 1);
        observe_flush();
        check_writes(start, NTAPS, 1, NTAPS);

        // Short 5-beat frame, padded with zeros
        wait_idle();
        start = wr_cnt;
        send_frame(5, 32'h100);
        check_eq("short_err_len", err_len, 1);
        check_eq("short_busy", busy, 1);
        wait_idle();
        next_cycle();
        check_writes(start, NTAPS, 32'h100, 5);
        check_eq("short_err_sticky", err_len, 1);

        // Long 35-beat frame, 3 beats dropped
        start = wr_cnt;
        send_frame(NTAPS + 3, 32'h400);
        check_eq("long_err_len", err_len, 1);
        observe_flush();
        check_writes(start, NTAPS, 32'h400, NTAPS);

        // A correct frame clears err_len
        wait_idle();
        start = wr_cnt;
        send_frame(NTAPS, 32'h500);
        check_eq("clear_err_len", err_len, 0);
        wait_idle();
        next_cycle();
        check_writes(start, NTAPS, 32'h500, NTAPS);

        // Config and sample in the same RUN cycle, then reset mid-LOAD
        start             = wr_cnt;
        s_axis_tvalid     = 1'b1;
        m_axis_tready     = 1'b1;
        s_axis_cfg_tvalid = 1'b1;
        s_axis_cfg_tdata  = 32'h300;
        #1;
        check_eq("same_fir_en", fir_en, 1);
        check_eq("same_s_tready", s_axis_tready, 1);
        check_eq("same_cfg_tready", s_axis_cfg_tready, 0);
        next_cycle();
        #1;
        check_eq("load_busy", busy, 1);
        check_eq("load_s_tready", s_axis_tready, 0);
        check_eq("load_m_tvalid", m_axis_tvalid, 0);
        check_eq("load_fir_en", fir_en, 0);
        check_eq("load_cfg_tready", s_axis_cfg_tready, 1);
        for (int j = 0; j < 10; j++) begin
            s_axis_cfg_tdata = 32'(32'h300 + j);
            next_cycle();
        end
        s_axis_cfg_tvalid = 1'b0;
        s_axis_tvalid     = 1'b0;
        areset            = 1'b1;
        next_cycle();
        areset = 1'b0;
        #1;
        check_eq("arst_busy", busy, 0);
        check_eq("arst_coef_we", coef_we, 0);
        check_eq("arst_cfg_tready", s_axis_cfg_tready, 0);
        check_writes(start, 10, 32'h300, 10);
        next_cycle();

        // Fresh frame after reset restarts at tap 0
        start = wr_cnt;
        send_frame(NTAPS, 32'h200);
        check_eq("fresh_err_len", err_len, 0);
        observe_flush();
        check_writes(start, NTAPS, 32'h200, NTAPS);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
